// File: rtl/int_vector_pkg.sv
// Shared types and helpers for the parametrised interrupt vector controller.
package int_vector_pkg;

  // Sequencer handshake states: idle, request raised, low vector byte, high vector byte.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    VLO  = 2'd2,
    VHI  = 2'd3
  } state_t;

  // SRC_ID must encode every pad plus the BRK and reset pseudo-sources.
  function automatic int src_id_width(input int num_src);
    return $clog2(num_src + 2);
  endfunction

  // BRK sits just above the last pad index.
  function automatic int brk_id(input int num_src);
    return num_src;
  endfunction

  // Reset sits just above BRK.
  function automatic int res_id(input int num_src);
    return num_src + 1;
  endfunction

endpackage

// File: rtl/int_src_detect.sv
// One interrupt pad: synchroniser, edge/level select, and a pending latch.
// A new edge that coincides with the acknowledge clear wins, so no edge is lost.
module int_src_detect #(
  parameter int SYNC_STAGES = 2,
  parameter bit IS_EDGE     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pad_n,
  input  logic i_clr,
  output logic o_pending
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_latch;
  logic                   w_level;
  logic                   w_rise;

  // Synced active-high level and its rising edge (falling edge on the pad).
  assign w_level = ~r_sync[SYNC_STAGES-1];
  assign w_rise  = w_level & ~r_prev;

  // Pad synchroniser chain; idles high so reset never looks like a request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad_n};
    end
  end

  // Previous synced level for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  // Edge latch: set has priority over the acknowledge clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_latch <= 1'b0;
    end else if (w_rise) begin
      r_latch <= 1'b1;
    end else if (i_clr) begin
      r_latch <= 1'b0;
    end
  end

  assign o_pending = IS_EDGE ? r_latch : w_level;

endmodule

// File: rtl/int_vector_ctrl.sv
// Interrupt vector controller: polls pads/BRK/reset at instruction boundaries,
// arbitrates by fixed priority, and drives the two-byte vector fetch.
//
// Handshakes: INT_REQ is held until the core pulses INT_ACK while in REQ; the
// acknowledged cycle is the last cycle INT_REQ is seen high. VEC_VALID/READY is
// a valid/ready pair: VEC_ADDR is stable while VEC_VALID=1 and READY=0, and a
// byte is consumed on each edge where both are 1 (low byte, then high byte).
module int_vector_ctrl
  import int_vector_pkg::*;
#(
  parameter int              NUM_SRC     = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = 4'b0001,
  parameter logic [NUM_SRC-1:0] NMI_MASK  = 4'b0001,
  parameter int              SYNC_STAGES = 2,
  parameter logic [15:0]     VEC_BASE    = 16'hFFF0,
  parameter logic [15:0]     RES_VEC     = 16'hFFFC,
  parameter logic [15:0]     BRK_VEC     = 16'hFFFE
) (
  input  logic                                PHI0,
  input  logic                                RES,
  input  logic [NUM_SRC-1:0]                  IRQ_N,
  input  logic                                I_FLAG,
  input  logic                                CHECK,
  input  logic                                BRK_SW,
  input  logic                                READY,
  input  logic                                INT_ACK,
  output logic                                INT_REQ,
  output logic                                VEC_VALID,
  output logic [15:0]                         VEC_ADDR,
  output logic [src_id_width(NUM_SRC)-1:0]    SRC_ID,
  output logic                                B_OUT,
  output logic                                DORES,
  output logic [NUM_SRC-1:0]                  PENDING,
  output logic [1:0]                          DBG_STATE
);

  localparam int              ID_W   = src_id_width(NUM_SRC);
  localparam logic [ID_W-1:0] BRK_ID = ID_W'(brk_id(NUM_SRC));
  localparam logic [ID_W-1:0] RES_ID = ID_W'(res_id(NUM_SRC));

  state_t             r_state;
  logic               r_int_req;
  logic               r_vec_valid;
  logic [15:0]        r_vec_addr;
  logic [ID_W-1:0]    r_src_id;
  logic               r_b_out;
  logic               r_dores;

  logic [NUM_SRC-1:0] w_pending;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_elig;
  logic               w_nmi_hit;
  logic [ID_W-1:0]    w_nmi_id;
  logic               w_msk_hit;
  logic [ID_W-1:0]    w_msk_id;
  logic               w_win_any;
  logic [ID_W-1:0]    w_win_id;
  logic               w_win_brk;
  logic [15:0]        w_vec;
  logic               w_ack;

  // Acknowledge only counts while a request is actually outstanding.
  assign w_ack = (r_state == REQ) && INT_ACK;

  // Per-pad detection; an edge latch clears when its own request is acknowledged.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign w_clr[k] = w_ack && (r_src_id == ID_W'(k));

    int_src_detect #(
      .SYNC_STAGES (SYNC_STAGES),
      .IS_EDGE     (EDGE_MASK[k])
    ) u_src (
      .i_clk     (PHI0),
      .i_rst     (RES),
      .i_pad_n   (IRQ_N[k]),
      .i_clr     (w_clr[k]),
      .o_pending (w_pending[k])
    );
  end

  // Non-maskable sources ignore the I flag.
  assign w_elig = w_pending & (NMI_MASK | {NUM_SRC{~I_FLAG}});

  // Fixed-priority arbitration: NMI (lowest index) > BRK > maskable (lowest index).
  always_comb begin
    w_nmi_hit = 1'b0;
    w_nmi_id  = '0;
    w_msk_hit = 1'b0;
    w_msk_id  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_nmi_hit && w_elig[k] && NMI_MASK[k]) begin
        w_nmi_hit = 1'b1;
        w_nmi_id  = ID_W'(k);
      end
      if (!w_msk_hit && w_elig[k] && !NMI_MASK[k]) begin
        w_msk_hit = 1'b1;
        w_msk_id  = ID_W'(k);
      end
    end
    w_win_any = 1'b1;
    w_win_brk = 1'b0;
    w_win_id  = '0;
    if (w_nmi_hit) begin
      w_win_id = w_nmi_id;
    end else if (BRK_SW) begin
      w_win_id  = BRK_ID;
      w_win_brk = 1'b1;
    end else if (w_msk_hit) begin
      w_win_id = w_msk_id;
    end else begin
      w_win_any = 1'b0;
    end
  end

  // Low vector byte address for the frozen winner (pads wrap within 16 bits).
  always_comb begin
    w_vec = VEC_BASE + {{(15-ID_W){1'b0}}, r_src_id, 1'b0};
    if (r_src_id == RES_ID) begin
      w_vec = RES_VEC;
    end else if (r_src_id == BRK_ID) begin
      w_vec = BRK_VEC;
    end
  end

  // Sequencer FSM with registered outputs; reset aborts any sequence in flight.
  always_ff @(posedge PHI0) begin
    if (RES) begin
      r_state     <= IDLE;
      r_int_req   <= 1'b0;
      r_vec_valid <= 1'b0;
      r_vec_addr  <= 16'h0000;
      r_src_id    <= '0;
      r_b_out     <= 1'b0;
      r_dores     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_dores) begin
            r_state   <= REQ;
            r_src_id  <= RES_ID;
            r_b_out   <= 1'b0;
            r_int_req <= 1'b1;
          end else if (CHECK && w_win_any) begin
            r_state   <= REQ;
            r_src_id  <= w_win_id;
            r_b_out   <= w_win_brk;
            r_int_req <= 1'b1;
          end
        end
        REQ: begin
          if (INT_ACK) begin
            r_state     <= VLO;
            r_int_req   <= 1'b0;
            r_vec_valid <= 1'b1;
            r_vec_addr  <= w_vec;
          end
        end
        VLO: begin
          if (READY) begin
            r_state    <= VHI;
            r_vec_addr <= w_vec + 16'd1;
          end
        end
        VHI: begin
          if (READY) begin
            r_state     <= IDLE;
            r_vec_valid <= 1'b0;
            if (r_src_id == RES_ID) begin
              r_dores <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign INT_REQ   = r_int_req;
  assign VEC_VALID = r_vec_valid;
  assign VEC_ADDR  = r_vec_addr;
  assign SRC_ID    = r_src_id;
  assign B_OUT     = r_b_out;
  assign DORES     = r_dores;
  assign PENDING   = w_pending;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_int_vector_ctrl.sv
// Directed bench for int_vector_ctrl with hand-computed expected values.
module tb_int_vector_ctrl;

  logic        PHI0;
  logic        RES;
  logic [3:0]  IRQ_N;
  logic        I_FLAG;
  logic        CHECK;
  logic        BRK_SW;
  logic        READY;
  logic        INT_ACK;
  logic        INT_REQ;
  logic        VEC_VALID;
  logic [15:0] VEC_ADDR;
  logic [2:0]  SRC_ID;
  logic        B_OUT;
  logic        DORES;
  logic [3:0]  PENDING;
  logic [1:0]  DBG_STATE;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] exp_q[$];

  int_vector_ctrl dut (
    .PHI0      (PHI0),
    .RES       (RES),
    .IRQ_N     (IRQ_N),
    .I_FLAG    (I_FLAG),
    .CHECK     (CHECK),
    .BRK_SW    (BRK_SW),
    .READY     (READY),
    .INT_ACK   (INT_ACK),
    .INT_REQ   (INT_REQ),
    .VEC_VALID (VEC_VALID),
    .VEC_ADDR  (VEC_ADDR),
    .SRC_ID    (SRC_ID),
    .B_OUT     (B_OUT),
    .DORES     (DORES),
    .PENDING   (PENDING),
    .DBG_STATE (DBG_STATE)
  );

  // Clock.
  initial PHI0 = 1'b0;
  always #5 PHI0 = ~PHI0;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge PHI0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check all reset-state outputs.
  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   INT_REQ,   0);
    chk({tag, "_vv"},    VEC_VALID, 0);
    chk({tag, "_addr"},  VEC_ADDR,  0);
    chk({tag, "_id"},    SRC_ID,    0);
    chk({tag, "_b"},     B_OUT,     0);
    chk({tag, "_dores"}, DORES,     1);
    chk({tag, "_pend"},  PENDING,   0);
    chk({tag, "_st"},    DBG_STATE, 0);
  endtask

  // Acknowledge the outstanding request and fetch both vector bytes with READY=1.
  task automatic serve(input string tag, input logic [2:0] id, input logic b,
                       input logic [15:0] vec);
    chk({tag, "_req"}, INT_REQ, 1);
    chk({tag, "_id"},  SRC_ID,  id);
    chk({tag, "_b"},   B_OUT,   b);
    exp_q.push_back(vec);
    exp_q.push_back(vec + 16'd1);
    INT_ACK = 1'b1;
    READY   = 1'b1;
    tick();
    INT_ACK = 1'b0;
    chk({tag, "_vv"},     VEC_VALID, 1);
    chk({tag, "_reqlo"},  INT_REQ,   0);
    chk({tag, "_lo"},     VEC_ADDR,  exp_q.pop_front());
    tick();
    chk({tag, "_hi"},     VEC_ADDR,  exp_q.pop_front());
    tick();
    chk({tag, "_vvoff"},  VEC_VALID, 0);
    chk({tag, "_idle"},   DBG_STATE, 0);
  endtask

  // Falling-edge pulse on one pad for a single cycle, then wait for the latch.
  task automatic pulse_pad(input int k);
    logic [3:0] v;
    v = 4'hF;
    v[k] = 1'b0;
    IRQ_N = v;
    tick();
    IRQ_N = 4'hF;
    tick();
    tick();
  endtask

  task automatic poll();
    CHECK = 1'b1;
    tick();
    CHECK = 1'b0;
  endtask

  initial begin
    RES = 1'b1; IRQ_N = 4'hF; I_FLAG = 1'b1; CHECK = 1'b0;
    BRK_SW = 1'b0; READY = 1'b1; INT_ACK = 1'b0;
    repeat (3) tick();
    chk_reset("rst");

    // Reset sequence runs without a poll.
    RES = 1'b0;
    tick();
    chk("res_dores", DORES, 1);
    serve("res", 3'd5, 1'b0, 16'hFFFC);
    chk("res_done", DORES, 0);
    chk("res_id", SRC_ID, 5);

    // Edge NMI on pad 0 is served even with I=1.
    I_FLAG = 1'b1;
    pulse_pad(0);
    chk("nmi_pend", PENDING, 4'b0001);
    poll();
    serve("nmi0", 3'd0, 1'b0, 16'hFFF0);
    chk("nmi_clr", PENDING, 4'b0000);

    // Level maskable pad 2: blocked by I=1, served once I=0.
    IRQ_N = 4'b1011;
    repeat (3) tick();
    chk("lvl_pend", PENDING, 4'b0100);
    poll();
    chk("lvl_mask_req", INT_REQ, 0);
    chk("lvl_mask_st", DBG_STATE, 0);
    I_FLAG = 1'b0;
    poll();
    serve("lvl2", 3'd2, 1'b0, 16'hFFF4);
    IRQ_N = 4'hF;
    repeat (3) tick();
    chk("lvl_gone", PENDING, 4'b0000);

    // BRK beats a maskable pad; the pad is served on the next poll.
    IRQ_N = 4'b1101;
    repeat (3) tick();
    BRK_SW = 1'b1;
    poll();
    BRK_SW = 1'b0;
    serve("brk", 3'd4, 1'b1, 16'hFFFE);
    poll();
    serve("lvl1", 3'd1, 1'b0, 16'hFFF2);
    IRQ_N = 4'hF;
    I_FLAG = 1'b1;
    repeat (3) tick();

    // New edge on pad 0 in the very cycle its previous request is acknowledged.
    pulse_pad(0);
    poll();
    chk("race_req", INT_REQ, 1);
    chk("race_id", SRC_ID, 0);
    IRQ_N = 4'b1110;
    tick();
    IRQ_N = 4'hF;
    tick();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    chk("race_pend", PENDING, 4'b0001);
    chk("race_lo", VEC_ADDR, 16'hFFF0);
    tick();
    chk("race_hi", VEC_ADDR, 16'hFFF1);
    tick();
    poll();
    serve("race2", 3'd0, 1'b0, 16'hFFF0);
    chk("race2_clr", PENDING, 4'b0000);

    // READY stall in VLO, then reset during VHI.
    pulse_pad(0);
    poll();
    INT_ACK = 1'b1;
    READY = 1'b0;
    tick();
    INT_ACK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", VEC_ADDR, 16'hFFF0);
      chk("stall_vv", VEC_VALID, 1);
    end
    READY = 1'b1;
    tick();
    chk("stall_hi", VEC_ADDR, 16'hFFF1);
    chk("stall_st", DBG_STATE, 3);
    RES = 1'b1;
    tick();
    chk_reset("abort");
    RES = 1'b0;
    tick();
    serve("res2", 3'd5, 1'b0, 16'hFFFC);
    chk("res2_done", DORES, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Guard against a runaway run.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
